// File: rtl/exec_unit_forwarder_if.sv
// Issue/forward bus between the reservation station, the execution unit and the CDB arbiter.
// master = issuing/arbitrating side, slave = exec_unit_forwarder.
interface exec_unit_forwarder_if;
  logic [41:0] in_op;
  logic        in_valid;
  logic        in_ready;
  logic        fwd_req;
  logic        fwd_grant;
  logic [22:0] fwd_out;

  modport master (
    output in_op,
    output in_valid,
    output fwd_grant,
    input  in_ready,
    input  fwd_req,
    input  fwd_out
  );

  modport slave (
    input  in_op,
    input  in_valid,
    input  fwd_grant,
    output in_ready,
    output fwd_req,
    output fwd_out
  );
endinterface

// File: rtl/exec_unit_forwarder.sv
// Single-issue execution unit whose results queue in an in-order FIFO until the CDB grants a slot.
// Optional feature macro MUL_EN: opcode 7 becomes a MUL_CYCLES-long multiply; otherwise it yields 0.
module exec_unit_forwarder #(
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  exec_unit_forwarder_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MUL_CYCLES < 1) begin : g_bad_params
    $error("exec_unit_forwarder: DEPTH must be a power of two >= 2 and MUL_CYCLES >= 1");
  end

  logic          stage_valid_q;
  logic [3:0]    stage_op_q;
  logic [5:0]    stage_rob_q;
  logic [15:0]   stage_a_q;
  logic [15:0]   stage_b_q;

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [21:0]   mem_q [DEPTH];

  logic          accept;
  logic          stage_push;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_nonempty;
  logic          mul_busy;
  logic [CW-1:0] occupancy;

  function automatic logic [15:0] aluResult(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] r;
    r = '0;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[3:0];
      4'd6:    r = a >> b[3:0];
`ifdef MUL_EN
      4'd7:    r = a * b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // A result in the stage already owns a FIFO slot, so admission counts it alongside the queue.
  assign occupancy     = count_q + CW'(stage_valid_q);
  assign bus.in_ready  = !mul_busy && (occupancy < DepthC) && !flush_i;
  assign accept        = bus.in_valid && bus.in_ready;

  assign fifo_nonempty = (count_q != '0);
  assign fifo_pop      = fifo_nonempty && bus.fwd_grant && !flush_i;
  assign fifo_push     = stage_push && !flush_i;

  assign bus.fwd_req   = fifo_nonempty;
  assign bus.fwd_out   = {fifo_pop, fifo_nonempty ? mem_q[rd_q] : 22'd0};

`ifdef MUL_EN
  localparam int CNTW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  assign mul_busy = (state_q == S_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // In IDLE the stage holds a 1-cycle ALU op; in MUL it holds the multiply until cnt runs out.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_push = 1'b0;
    case (state_q)
      S_IDLE: begin
        stage_push = stage_valid_q;
        if (accept && bus.in_op[41:38] == 4'd7) begin
          state_d = S_MUL;
          cnt_d   = CNTW'(MUL_CYCLES - 1);
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          stage_push = stage_valid_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end
`else
  assign mul_busy   = 1'b0;
  assign stage_push = stage_valid_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_op_q    <= '0;
      stage_rob_q   <= '0;
      stage_a_q     <= '0;
      stage_b_q     <= '0;
    end else if (flush_i) begin
      stage_valid_q <= 1'b0;
    end else if (accept) begin
      stage_valid_q <= 1'b1;
      stage_op_q    <= bus.in_op[41:38];
      stage_rob_q   <= bus.in_op[37:32];
      stage_a_q     <= bus.in_op[31:16];
      stage_b_q     <= bus.in_op[15:0];
    end else if (stage_push) begin
      stage_valid_q <= 1'b0;
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (fifo_push) wr_d = wr_q + PW'(1);
      if (fifo_pop)  rd_d = rd_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_q] <= {stage_rob_q, aluResult(stage_op_q, stage_a_q, stage_b_q)};
    end
  end

endmodule
